pma_region_checker: RTL and testbench

PMA_REGION_CHECKER -- requirements
Module: pmaregionchecker

---
 rtl/pma_region_checker.sv | 252 +++++++++++++++++++++++++
 tb/tb_pma_region_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pma_region_checker.sv
// pma_region_checker
//   Physical memory attribute checker with NREGIONS programmable regions.
//   Each request is matched against all enabled regions; the lowest-index
//   region that fully contains the access supplies the attributes, and a
//   registered response reports hit/attributes/access faults one cycle later.
//   The first faulting response is latched into a fault record until cleared.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   CfgWrEn/CfgIdx/CfgBase/CfgTop/CfgAttr
//                       region programming; CfgAttr = {Lock,En,R,W,X,Atomic,
//                       Cacheable,Idempotent}; CfgTop is exclusive
//   CfgErr              one-cycle pulse after a rejected write
//   ReqValid/PhysicalAddress/Size/*Access
//                       access request (bytes = 1 << Size)
//   RspValid/Cacheable/Idempotent/RegionHit/RegionIdx/*AccessFault
//                       registered response, one cycle after the request
//   FaultClr/FaultValid/FaultAddr/FaultCause/FaultOverflow
//                       sticky fault record; FaultCause = {nomatch,perm,atomic}
module pma_region_checker #(
  parameter int PA_BITS  = 34,
  parameter int NREGIONS = 8,
  parameter int IDXW     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               CfgWrEn,
  input  logic [IDXW-1:0]    CfgIdx,
  input  logic [PA_BITS-1:0] CfgBase,
  input  logic [PA_BITS:0]   CfgTop,
  input  logic [7:0]         CfgAttr,
  output logic               CfgErr,
  input  logic               ReqValid,
  input  logic [PA_BITS-1:0] PhysicalAddress,
  input  logic [1:0]         Size,
  input  logic               ReadAccess,
  input  logic               WriteAccess,
  input  logic               ExecuteAccess,
  input  logic               AtomicAccess,
  output logic               RspValid,
  output logic               Cacheable,
  output logic               Idempotent,
  output logic               RegionHit,
  output logic [IDXW-1:0]    RegionIdx,
  output logic               InstrAccessFault,
  output logic               LoadAccessFault,
  output logic               StoreAmoAccessFault,
  input  logic               FaultClr,
  output logic               FaultValid,
  output logic [PA_BITS-1:0] FaultAddr,
  output logic [2:0]         FaultCause,
  output logic               FaultOverflow
);

  localparam int A_LOCK  = 7;
  localparam int A_EN    = 6;
  localparam int A_R     = 5;
  localparam int A_W     = 4;
  localparam int A_X     = 3;
  localparam int A_ATOM  = 2;
  localparam int A_CACHE = 1;
  localparam int A_IDEM  = 0;

  // Region state
  logic [PA_BITS-1:0] base_q [NREGIONS];
  logic [PA_BITS-1:0] base_d [NREGIONS];
  logic [PA_BITS:0]   top_q  [NREGIONS];
  logic [PA_BITS:0]   top_d  [NREGIONS];
  logic [7:0]         attr_q [NREGIONS];
  logic [7:0]         attr_d [NREGIONS];

  logic [NREGIONS-1:0] wr_hit;
  logic [NREGIONS-1:0] match;
  logic                cfg_err_q, cfg_err_d;

  // End address one bit wider than the address so a top-of-space access
  // cannot wrap around and appear to fit.
  logic [PA_BITS:0] req_end;
  assign req_end = {1'b0, PhysicalAddress} + ((PA_BITS+1)'(1) << Size);

  genvar gi;
  generate
    for (gi = 0; gi < NREGIONS; gi++) begin : g_region
      // Locked regions never accept a write, so Lock can only fall via reset.
      assign wr_hit[gi] = CfgWrEn && (CfgIdx == IDXW'(gi)) && !attr_q[gi][A_LOCK];
      assign match[gi]  = attr_q[gi][A_EN] && (PhysicalAddress >= base_q[gi]) &&
                          (req_end <= top_q[gi]);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NREGIONS; i++) begin
      base_d[i] = base_q[i];
      top_d[i]  = top_q[i];
      attr_d[i] = attr_q[i];
      if (wr_hit[i]) begin
        base_d[i] = CfgBase;
        top_d[i]  = CfgTop;
        attr_d[i] = CfgAttr;
      end
    end
    // No region claimed the write: either out of range or locked.
    cfg_err_d = CfgWrEn && (wr_hit == '0);
  end

  // Request evaluation (always against the configuration held before any
  // same-cycle write takes effect)
  logic            sel_hit;
  logic [IDXW-1:0] sel_idx;
  logic [7:0]      sel_attr;
  logic            any_acc, f_nomatch, f_perm, f_atom, fault;
  logic [2:0]      cause;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_cache_q, rsp_cache_d;
  logic               rsp_idem_q, rsp_idem_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic [IDXW-1:0]    rsp_idx_q, rsp_idx_d;
  logic               rsp_if_q, rsp_if_d;
  logic               rsp_lf_q, rsp_lf_d;
  logic               rsp_sf_q, rsp_sf_d;
  logic               rsp_fault_q, rsp_fault_d;
  logic [PA_BITS-1:0] rsp_addr_q, rsp_addr_d;
  logic [2:0]         rsp_cause_q, rsp_cause_d;

  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    sel_attr = '0;
    // Scan downward so the lowest matching index is the last one written.
    for (int i = NREGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_hit  = 1'b1;
        sel_idx  = IDXW'(i);
        sel_attr = attr_q[i];
      end
    end
    any_acc   = ReadAccess | WriteAccess | ExecuteAccess | AtomicAccess;
    f_nomatch = any_acc && !sel_hit;
    f_perm    = sel_hit && ((ReadAccess && !sel_attr[A_R]) ||
                            (WriteAccess && !sel_attr[A_W]) ||
                            (ExecuteAccess && !sel_attr[A_X]));
    f_atom    = sel_hit && AtomicAccess && !sel_attr[A_ATOM];
    fault     = f_nomatch | f_perm | f_atom;
    if (f_nomatch)   cause = 3'b100;
    else if (f_perm) cause = 3'b010;
    else if (f_atom) cause = 3'b001;
    else             cause = 3'b000;

    rsp_valid_d = ReqValid;
    rsp_hit_d   = ReqValid && sel_hit;
    rsp_idx_d   = rsp_hit_d ? sel_idx : '0;
    rsp_cache_d = rsp_hit_d && sel_attr[A_CACHE];
    rsp_idem_d  = rsp_hit_d && sel_attr[A_IDEM];
    rsp_fault_d = ReqValid && fault;
    rsp_if_d    = rsp_fault_d && ExecuteAccess;
    rsp_lf_d    = rsp_fault_d && ReadAccess;
    rsp_sf_d    = rsp_fault_d && (WriteAccess || AtomicAccess);
    rsp_addr_d  = PhysicalAddress;
    rsp_cause_d = cause;
  end

  // Fault record: fed by the response currently on the outputs
  logic               fault_valid_q, fault_valid_d;
  logic [PA_BITS-1:0] fault_addr_q, fault_addr_d;
  logic [2:0]         fault_cause_q, fault_cause_d;
  logic               fault_ovf_q, fault_ovf_d;

  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_addr_d  = fault_addr_q;
    fault_cause_d = fault_cause_q;
    fault_ovf_d   = fault_ovf_q;
    // Clear first, so a fault arriving with FaultClr becomes the new record.
    if (FaultClr) begin
      fault_valid_d = 1'b0;
      fault_ovf_d   = 1'b0;
    end
    if (rsp_fault_q) begin
      if (!fault_valid_d) begin
        fault_valid_d = 1'b1;
        fault_addr_d  = rsp_addr_q;
        fault_cause_d = rsp_cause_q;
      end else begin
        fault_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGIONS; i++) begin
        base_q[i] <= '0;
        top_q[i]  <= '0;
        attr_q[i] <= '0;
      end
      cfg_err_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_cache_q   <= 1'b0;
      rsp_idem_q    <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_idx_q     <= '0;
      rsp_if_q      <= 1'b0;
      rsp_lf_q      <= 1'b0;
      rsp_sf_q      <= 1'b0;
      rsp_fault_q   <= 1'b0;
      rsp_addr_q    <= '0;
      rsp_cause_q   <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= '0;
      fault_ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREGIONS; i++) begin
        base_q[i] <= base_d[i];
        top_q[i]  <= top_d[i];
        attr_q[i] <= attr_d[i];
      end
      cfg_err_q     <= cfg_err_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_cache_q   <= rsp_cache_d;
      rsp_idem_q    <= rsp_idem_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_idx_q     <= rsp_idx_d;
      rsp_if_q      <= rsp_if_d;
      rsp_lf_q      <= rsp_lf_d;
      rsp_sf_q      <= rsp_sf_d;
      rsp_fault_q   <= rsp_fault_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_cause_q   <= rsp_cause_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
      fault_ovf_q   <= fault_ovf_d;
    end
  end

  assign CfgErr              = cfg_err_q;
  assign RspValid            = rsp_valid_q;
  assign Cacheable           = rsp_cache_q;
  assign Idempotent          = rsp_idem_q;
  assign RegionHit           = rsp_hit_q;
  assign RegionIdx           = rsp_idx_q;
  assign InstrAccessFault    = rsp_if_q;
  assign LoadAccessFault     = rsp_lf_q;
  assign StoreAmoAccessFault = rsp_sf_q;
  assign FaultValid          = fault_valid_q;
  assign FaultAddr           = fault_addr_q;
  assign FaultCause          = fault_cause_q;
  assign FaultOverflow       = fault_ovf_q;

endmodule

// File: tb/tb_pma_region_checker.sv
// tb_pma_region_checker
//   Directed scenarios followed by random traffic, each cycle checked
//   against a behavioural model of the region table, the response and the
//   fault record.
module tb_pma_region_checker;

  localparam int PA = 34;
  localparam int NR = 8;
  localparam int IW = 4;

  logic          clk;
  logic          reset_n;
  logic          CfgWrEn;
  logic [IW-1:0] CfgIdx;
  logic [PA-1:0] CfgBase;
  logic [PA:0]   CfgTop;
  logic [7:0]    CfgAttr;
  logic          CfgErr;
  logic          ReqValid;
  logic [PA-1:0] PhysicalAddress;
  logic [1:0]    Size;
  logic          ReadAccess, WriteAccess, ExecuteAccess, AtomicAccess;
  logic          RspValid, Cacheable, Idempotent, RegionHit;
  logic [IW-1:0] RegionIdx;
  logic          InstrAccessFault, LoadAccessFault, StoreAmoAccessFault;
  logic          FaultClr;
  logic          FaultValid;
  logic [PA-1:0] FaultAddr;
  logic [2:0]    FaultCause;
  logic          FaultOverflow;

  pma_region_checker #(.PA_BITS(PA), .NREGIONS(NR), .IDXW(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .CfgWrEn(CfgWrEn), .CfgIdx(CfgIdx), .CfgBase(CfgBase), .CfgTop(CfgTop),
    .CfgAttr(CfgAttr), .CfgErr(CfgErr),
    .ReqValid(ReqValid), .PhysicalAddress(PhysicalAddress), .Size(Size),
    .ReadAccess(ReadAccess), .WriteAccess(WriteAccess),
    .ExecuteAccess(ExecuteAccess), .AtomicAccess(AtomicAccess),
    .RspValid(RspValid), .Cacheable(Cacheable), .Idempotent(Idempotent),
    .RegionHit(RegionHit), .RegionIdx(RegionIdx),
    .InstrAccessFault(InstrAccessFault), .LoadAccessFault(LoadAccessFault),
    .StoreAmoAccessFault(StoreAmoAccessFault),
    .FaultClr(FaultClr), .FaultValid(FaultValid), .FaultAddr(FaultAddr),
    .FaultCause(FaultCause), .FaultOverflow(FaultOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state
  longint   m_base [NR];
  longint   m_top  [NR];
  bit [7:0] m_attr [NR];
  bit       m_pend;            // response on the outputs is a fault
  longint   m_pend_addr;
  bit [2:0] m_pend_cause;
  bit       m_fv, m_fo;
  longint   m_fa;
  bit [2:0] m_fc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    CfgWrEn = 0; CfgIdx = '0; CfgBase = '0; CfgTop = '0; CfgAttr = '0;
    ReqValid = 0; PhysicalAddress = '0; Size = '0;
    ReadAccess = 0; WriteAccess = 0; ExecuteAccess = 0; AtomicAccess = 0;
    FaultClr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = 0; m_top[i] = 0; m_attr[i] = 0;
    end
    m_pend = 0; m_pend_addr = 0; m_pend_cause = 0;
    m_fv = 0; m_fo = 0; m_fa = 0; m_fc = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rv"},   RspValid, 0);
    chk({tag, "_hit"},  RegionHit, 0);
    chk({tag, "_idx"},  RegionIdx, 0);
    chk({tag, "_c"},    Cacheable, 0);
    chk({tag, "_i"},    Idempotent, 0);
    chk({tag, "_iaf"},  InstrAccessFault, 0);
    chk({tag, "_laf"},  LoadAccessFault, 0);
    chk({tag, "_saf"},  StoreAmoAccessFault, 0);
    chk({tag, "_cerr"}, CfgErr, 0);
    chk({tag, "_fv"},   FaultValid, 0);
    chk({tag, "_fa"},   FaultAddr, 0);
    chk({tag, "_fc"},   FaultCause, 0);
    chk({tag, "_fo"},   FaultOverflow, 0);
  endtask

  // Asserts reset away from the clock edge, checks the async clear, holds
  // reset across one edge, then releases it.
  task automatic apply_reset(input string tag);
    reset_n = 0;
    model_reset();
    #1;
    chk_all_zero(tag);
    @(posedge clk);
    #1;
    reset_n = 1;
    idle_inputs();
  endtask

  task automatic set_cfg(input int idx, input longint base, input longint top, input bit [7:0] attr);
    CfgWrEn = 1; CfgIdx = idx[IW-1:0]; CfgBase = base[PA-1:0]; CfgTop = top[PA:0]; CfgAttr = attr;
  endtask

  task automatic set_req(input longint addr, input int sz, input bit r, input bit w, input bit x, input bit a);
    ReqValid = 1; PhysicalAddress = addr[PA-1:0]; Size = sz[1:0];
    ReadAccess = r; WriteAccess = w; ExecuteAccess = x; AtomicAccess = a;
  endtask

  // One clock: compute what the DUT must show after this edge, step, compare,
  // then fold the cycle into the model.
  task automatic tick(input string tag);
    longint   addr, nbytes;
    bit       found, any, perm, atom, nom, flt, e_cerr, do_wr;
    int       sidx;
    bit [7:0] sa;
    bit [2:0] cause;
    bit       n_fv, n_fo;
    longint   n_fa;
    bit [2:0] n_fc;

    addr   = longint'(PhysicalAddress);
    nbytes = longint'(1) << Size;
    found  = 0; sidx = 0; sa = 0;
    for (int i = 0; i < NR; i++) begin
      if (!found && m_attr[i][6] && addr >= m_base[i] && addr + nbytes <= m_top[i]) begin
        found = 1; sidx = i; sa = m_attr[i];
      end
    end
    any  = ReadAccess || WriteAccess || ExecuteAccess || AtomicAccess;
    nom  = any && !found;
    perm = found && ((ReadAccess && !sa[5]) || (WriteAccess && !sa[4]) || (ExecuteAccess && !sa[3]));
    atom = found && AtomicAccess && !sa[2];
    flt  = ReqValid && (nom || perm || atom);
    cause = nom ? 3'b100 : perm ? 3'b010 : atom ? 3'b001 : 3'b000;

    e_cerr = 0; do_wr = 0;
    if (CfgWrEn) begin
      if (int'(CfgIdx) >= NR) e_cerr = 1;
      else if (m_attr[CfgIdx][7]) e_cerr = 1;
      else do_wr = 1;
    end

    n_fv = m_fv; n_fo = m_fo; n_fa = m_fa; n_fc = m_fc;
    if (FaultClr) begin n_fv = 0; n_fo = 0; end
    if (m_pend) begin
      if (n_fv) n_fo = 1;
      else begin n_fv = 1; n_fa = m_pend_addr; n_fc = m_pend_cause; end
    end

    @(posedge clk);
    #1;
    chk({tag, "_rv"},   RspValid, ReqValid);
    chk({tag, "_hit"},  RegionHit, ReqValid && found);
    chk({tag, "_idx"},  RegionIdx, (ReqValid && found) ? sidx : 0);
    chk({tag, "_c"},    Cacheable, ReqValid && found && sa[1]);
    chk({tag, "_i"},    Idempotent, ReqValid && found && sa[0]);
    chk({tag, "_iaf"},  InstrAccessFault, flt && ExecuteAccess);
    chk({tag, "_laf"},  LoadAccessFault, flt && ReadAccess);
    chk({tag, "_saf"},  StoreAmoAccessFault, flt && (WriteAccess || AtomicAccess));
    chk({tag, "_cerr"}, CfgErr, e_cerr);
    chk({tag, "_fv"},   FaultValid, n_fv);
    chk({tag, "_fa"},   FaultAddr, n_fa);
    chk({tag, "_fc"},   FaultCause, n_fc);
    chk({tag, "_fo"},   FaultOverflow, n_fo);
    $display("[%0t] %s req=%0b addr=%0h sz=%0d rwxa=%0b%0b%0b%0b hit=%0b idx=%0d flt=%0b cfg=%0b cerr=%0b fv=%0b fc=%0b fo=%0b",
             $time, tag, ReqValid, addr, Size, ReadAccess, WriteAccess, ExecuteAccess, AtomicAccess,
             RegionHit, RegionIdx, flt, CfgWrEn, CfgErr, FaultValid, FaultCause, FaultOverflow);

    if (do_wr) begin
      m_base[CfgIdx] = longint'(CfgBase);
      m_top[CfgIdx]  = longint'(CfgTop);
      m_attr[CfgIdx] = CfgAttr;
    end
    m_pend = flt; m_pend_addr = addr; m_pend_cause = cause;
    m_fv = n_fv; m_fo = n_fo; m_fa = n_fa; m_fc = n_fc;
    idle_inputs();
  endtask

  initial begin
    longint base, addr;
    idle_inputs();
    model_reset();
    reset_n = 1;
    #2;
    apply_reset("reset0");

    // Basic hit at the very end of region 0
    set_cfg(0, 64'h8000_0000, 64'h8000_1000, 8'h7E); tick("cfg_r0");
    set_req(64'h8000_0FF8, 3, 1, 0, 0, 0); tick("rd_end_fit");
    chk("rd_end_fit_c", Cacheable, 1);
    chk("rd_end_fit_lf", LoadAccessFault, 0);
    tick("idle");

    // Straddling Top is a no-match fault
    set_req(64'h8000_0FFC, 3, 1, 0, 0, 0); tick("rd_straddle");
    chk("rd_straddle_lf", LoadAccessFault, 1);
    tick("rec_straddle");
    chk("rec_straddle_fc", FaultCause, 3'b100);
    chk("rec_straddle_fa", FaultAddr, 64'h8000_0FFC);

    // Overlap priority, then fallback to the write-protected region
    set_cfg(1, 64'h8000_0800, 64'h8000_2000, 8'h6B); FaultClr = 1; tick("cfg_r1");
    set_req(64'h8000_0900, 2, 0, 1, 0, 0); tick("wr_overlap");
    chk("wr_overlap_idx", RegionIdx, 0);
    tick("idle");
    set_cfg(0, 64'h8000_0000, 64'h8000_1000, 8'h00); tick("dis_r0");
    set_req(64'h8000_0900, 2, 0, 1, 0, 0); tick("wr_perm");
    chk("wr_perm_saf", StoreAmoAccessFault, 1);
    tick("rec_perm");
    chk("rec_perm_fc", FaultCause, 3'b010);

    // Atomic to a region without Atomic
    FaultClr = 1; set_req(64'h8000_0900, 3, 0, 0, 0, 1); tick("amo");
    chk("amo_saf", StoreAmoAccessFault, 1);
    tick("rec_amo");
    chk("rec_amo_fc", FaultCause, 3'b001);

    // Overflow, then clear coinciding with a third fault
    FaultClr = 1; tick("clr");
    set_req(64'h10, 0, 1, 0, 0, 0); tick("f1");
    tick("f1_rec");
    set_req(64'h8000_0900, 0, 0, 1, 0, 0); tick("f2");
    tick("f2_rec");
    chk("ovf_fa", FaultAddr, 64'h10);
    chk("ovf_fo", FaultOverflow, 1);
    set_req(64'h8000_0904, 0, 0, 0, 0, 1); tick("f3");
    FaultClr = 1; tick("f3_clr");
    chk("f3_fa", FaultAddr, 64'h8000_0904);
    chk("f3_fo", FaultOverflow, 0);

    // Lock, rejected writes, reset unlocks
    set_cfg(2, 64'h1000, 64'h2000, 8'hE1); tick("lock_r2");
    set_cfg(2, 64'h3000, 64'h4000, 8'h7F); tick("wr_locked");
    chk("wr_locked_cerr", CfgErr, 1);
    tick("cerr_pulse_end");
    set_req(64'h1000, 2, 1, 0, 0, 0); tick("rd_locked");
    chk("rd_locked_i", Idempotent, 1);
    set_cfg(9, 64'h0, 64'h100, 8'h7F); tick("wr_oob");
    chk("wr_oob_cerr", CfgErr, 1);
    apply_reset("reset1");
    set_cfg(2, 64'h3000, 64'h4000, 8'h7F); tick("wr_unlocked");
    set_req(64'h3000, 1, 1, 0, 0, 0); tick("rd_new_r2");
    chk("rd_new_r2_c", Cacheable, 1);

    // Reset arriving while a request is in flight
    set_req(64'h3000, 0, 1, 0, 0, 0);
    #2;
    apply_reset("reset_mid");
    tick("post_reset_idle");
    set_req(64'h3000, 0, 1, 0, 0, 0); tick("first_req");
    chk("first_req_rv", RspValid, 1);

    // Random traffic, including same-cycle config writes
    for (int it = 0; it < 400; it++) begin
      if (it == 200) apply_reset("reset_rand");
      if ($urandom_range(0, 2) == 0) begin
        base = longint'($urandom_range(0, 7)) * 64'h1000 + longint'($urandom_range(0, 15)) * 8;
        set_cfg($urandom_range(0, 9), base, base + longint'($urandom_range(0, 32'h3000)),
                {($urandom_range(0, 15) == 0), 7'($urandom)});
      end
      if ($urandom_range(0, 3) != 0) begin
        addr = longint'($urandom_range(0, 32'h8800));
        set_req(addr, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      FaultClr = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
